// File: rtl/inst_encoder_pkg.sv
// Shared types, RV32I field constants, immediate range limits and per-format
// bit-packing helpers for the instruction encoder.
package inst_encoder_pkg;

  typedef enum logic [5:0] {
    I_NOP, I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU,
    I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI,
    I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    I_MUL, I_MULH, I_MULHSU, I_MULHU, I_DIV, I_DIVU, I_REM, I_REMU,
    I_LR_W, I_SC_W, I_AMOADD_W
  } e_all_inst;

  typedef enum logic [0:0] {S_IDLE, S_EXP2} e_enc_state;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX = 32'sd4095;
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX = 32'sd1048575;

  function automatic logic in_range(input logic [31:0] v, input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

  function automatic logic [2:0] funct3_of(input e_all_inst inst);
    logic [2:0] f3;
    f3 = 3'b000;
    case (inst)
      I_BNE, I_LH, I_SH, I_SLLI, I_SLL:                f3 = 3'b001;
      I_LW, I_SW, I_SLTI, I_SLT:                       f3 = 3'b010;
      I_SLTIU, I_SLTU:                                 f3 = 3'b011;
      I_BLT, I_LBU, I_XORI, I_XOR:                     f3 = 3'b100;
      I_BGE, I_LHU, I_SRLI, I_SRAI, I_SRL, I_SRA:      f3 = 3'b101;
      I_BLTU, I_ORI, I_OR:                             f3 = 3'b110;
      I_BGEU, I_ANDI, I_AND:                           f3 = 3'b111;
      default:                                         f3 = 3'b000;
    endcase
    return f3;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Output word FIFO: power-of-two depth, pointers wrap naturally, storage
// cleared on reset so the head reads zero before the first push.
module enc_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (!push_i && pop_i) cnt_q <= cnt_q - CW'(1);
      else                       cnt_q <= cnt_q;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_encoder.sv
// RV32I descriptor-to-machine-word encoder with a buffered valid/ready output;
// out-of-range ADDI from x0 is split into LUI + ADDI.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  e_all_inst        req_inst,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             err_illegal,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  e_enc_state       state_q, state_d;
  logic [31:0]      exp_word_q, exp_word_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      enc_word_s, exp_word_s, push_word_s;
  logic             enc_ok_s, enc_exp_s, push_s, accept_s, imm_i_ok_s;
  logic [2:0]       f3_s;
  logic [6:0]       f7_s;
  logic [19:0]      hi20_s;
  logic [CW-1:0]    fifo_cnt_s;

  // one slot is always held back so the second half of an expansion fits
  assign req_ready = (state_q == S_IDLE) && (fifo_cnt_s <= CW'(DEPTH - 2));
  assign accept_s  = req_valid && req_ready;

  // descriptor to word translation and legality check
  always_comb begin
    enc_word_s = NOP_WORD;
    enc_ok_s   = 1'b0;
    enc_exp_s  = 1'b0;
    f3_s       = funct3_of(req_inst);
    f7_s       = (req_inst == I_SUB || req_inst == I_SRA || req_inst == I_SRAI) ? F7_ALT : F7_BASE;
    imm_i_ok_s = in_range(req_imm, IMM_I_MIN, IMM_I_MAX);
    hi20_s     = req_imm[31:12] + {19'h0, req_imm[11]};
    exp_word_s = enc_i(req_imm[11:0], req_rd, F3_ADD, req_rd, OPC_OPIMM);
    case (req_inst)
      I_NOP: enc_ok_s = 1'b1;
      I_LUI, I_AUIPC: begin
        enc_word_s = enc_u(req_imm[31:12], req_rd, (req_inst == I_LUI) ? OPC_LUI : OPC_AUIPC);
        enc_ok_s   = (req_imm[11:0] == 12'h000);
      end
      I_JAL: begin
        enc_word_s = enc_j(req_imm[20:0], req_rd);
        enc_ok_s   = in_range(req_imm, IMM_J_MIN, IMM_J_MAX) && !req_imm[0];
      end
      I_JALR: begin
        enc_word_s = enc_i(req_imm[11:0], req_rs1, f3_s, req_rd, OPC_JALR);
        enc_ok_s   = imm_i_ok_s;
      end
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU: begin
        enc_word_s = enc_b(req_imm[12:0], req_rs2, req_rs1, f3_s);
        enc_ok_s   = in_range(req_imm, IMM_B_MIN, IMM_B_MAX) && !req_imm[0];
      end
      I_LB, I_LH, I_LW, I_LBU, I_LHU: begin
        enc_word_s = enc_i(req_imm[11:0], req_rs1, f3_s, req_rd, OPC_LOAD);
        enc_ok_s   = imm_i_ok_s;
      end
      I_SB, I_SH, I_SW: begin
        enc_word_s = enc_s(req_imm[11:0], req_rs2, req_rs1, f3_s);
        enc_ok_s   = imm_i_ok_s;
      end
      I_ADDI: begin
        if (imm_i_ok_s) begin
          enc_word_s = enc_i(req_imm[11:0], req_rs1, f3_s, req_rd, OPC_OPIMM);
          enc_ok_s   = 1'b1;
        end else if (req_rs1 == 5'd0) begin
          enc_word_s = enc_u(hi20_s, req_rd, OPC_LUI);
          enc_ok_s   = 1'b1;
          enc_exp_s  = 1'b1;
        end else begin
          enc_ok_s   = 1'b0;
        end
      end
      I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI: begin
        enc_word_s = enc_i(req_imm[11:0], req_rs1, f3_s, req_rd, OPC_OPIMM);
        enc_ok_s   = imm_i_ok_s;
      end
      I_SLLI, I_SRLI, I_SRAI: begin
        enc_word_s = enc_r(f7_s, req_imm[4:0], req_rs1, f3_s, req_rd, OPC_OPIMM);
        enc_ok_s   = (req_imm[31:5] == 27'h0);
      end
      I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND: begin
        enc_word_s = enc_r(f7_s, req_rs2, req_rs1, f3_s, req_rd, OPC_OP);
        enc_ok_s   = 1'b1;
      end
      default: enc_ok_s = 1'b0;
    endcase
  end

  // FSM next state, push control and counters
  always_comb begin
    state_d     = state_q;
    exp_word_d  = exp_word_q;
    err_d       = 1'b0;
    push_s      = 1'b0;
    push_word_s = enc_word_s;
    case (state_q)
      S_IDLE: begin
        if (accept_s && !enc_ok_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          push_s = 1'b1;
          if (enc_exp_s) begin
            state_d    = S_EXP2;
            exp_word_d = exp_word_s;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXP2: begin
        push_s      = 1'b1;
        push_word_s = exp_word_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = push_s ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      exp_word_q <= 32'h0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      exp_word_q <= exp_word_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_s),
    .data_i (push_word_s),
    .pop_i  (out_valid && out_ready),
    .data_o (out_word),
    .valid_o(out_valid),
    .count_o(fifo_cnt_s)
  );

  assign err_illegal = err_q;
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: stimulus queues hand-computed words, a
// monitor pops and compares every word the DUT hands over.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             out_ready = 1'b1;
  e_all_inst        req_inst = I_NOP;
  logic [4:0]       req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
  logic [31:0]      req_imm = 32'h0;
  logic             req_ready, out_valid, err_illegal;
  logic [31:0]      out_word;
  logic [CNT_W-1:0] word_cnt;

  int n_total = 0, n_pass = 0, err_pending = 0, exp_cnt = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int          pop_cyc_q[$];

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_inst(req_inst), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .err_illegal(err_illegal), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back(w);
    exp_cnt++;
  endtask

  task automatic send(input e_all_inst inst, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_inst = inst; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_total++;
      $display("FAIL send_timeout: req_ready 0 after 50 cycles, required 1");
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  // monitor: every handed-over word and every error pulse is checked
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got 0x%08h, required no word", out_word);
      end else begin
        chk("out_word", out_word, exp_q.pop_front());
      end
    end
    if (rst_n && err_illegal) begin
      n_total++;
      if (err_pending > 0) begin
        n_pass++;
        err_pending--;
      end else begin
        $display("FAIL err_illegal: got 1, required 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 32'd1);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_err", err_illegal, 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    expect_word(32'h0050_0093);
    send(I_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("latency_valid", out_valid, 32'd1);
    drain();
    chk("cnt_addi", word_cnt, exp_cnt);

    expect_word(32'h0020_81B3); send(I_ADD,  5'd3, 5'd1, 5'd2, 32'd0);
    expect_word(32'h0020_A623); send(I_SW,   5'd0, 5'd1, 5'd2, 32'd12);
    expect_word(32'h0020_8463); send(I_BEQ,  5'd0, 5'd1, 5'd2, 32'd8);
    expect_word(32'h4020_81B3); send(I_SUB,  5'd3, 5'd1, 5'd2, 32'd0);
    expect_word(32'hFE20_9EE3); send(I_BNE,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    expect_word(32'hFFC0_A183); send(I_LW,   5'd3, 5'd1, 5'd0, 32'hFFFF_FFFC);
    expect_word(32'h4031_5093); send(I_SRAI, 5'd1, 5'd2, 5'd0, 32'd3);
    expect_word(32'h0080_00EF); send(I_JAL,  5'd1, 5'd0, 5'd0, 32'd8);
    expect_word(32'h1234_52B7); send(I_LUI,  5'd5, 5'd0, 5'd0, 32'h1234_5000);
    expect_word(32'h0000_0013); send(I_NOP,  5'd0, 5'd0, 5'd0, 32'd0);
    drain();
    chk("cnt_formats", word_cnt, exp_cnt);

    pop_cyc_q.delete();
    expect_word(32'h1234_52B7);
    expect_word(32'h6782_8293);
    send(I_ADDI, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    drain();
    if (pop_cyc_q.size() >= 2) chk("exp_consecutive", pop_cyc_q[1] - pop_cyc_q[0], 32'd1);
    else chk("exp_pop_count", pop_cyc_q.size(), 32'd2);
    expect_word(32'h0000_12B7);
    expect_word(32'h8002_8293);
    send(I_ADDI, 5'd5, 5'd0, 5'd0, 32'h0000_0800);
    drain();
    chk("cnt_expand", word_cnt, exp_cnt);

    err_pending++; send(I_BEQ,  5'd0, 5'd1, 5'd2, 32'd3);
    err_pending++; send(I_ADDI, 5'd5, 5'd1, 5'd0, 32'h0000_1000);
    err_pending++; send(I_MUL,  5'd1, 5'd2, 5'd3, 32'd0);
    err_pending++; send(I_LUI,  5'd1, 5'd0, 5'd0, 32'h0000_0123);
    err_pending++; send(I_SLLI, 5'd1, 5'd2, 5'd0, 32'd32);
    err_pending++; send(I_JAL,  5'd1, 5'd0, 5'd0, 32'h0010_0000);
    err_pending++; send(I_SW,   5'd0, 5'd1, 5'd2, 32'd2048);
    drain();
    chk("cnt_illegal", word_cnt, exp_cnt);
    chk("err_all_seen", err_pending, 32'd0);

    @(posedge clk); #1; out_ready = 1'b0;
    expect_word(32'h0010_0093); send(I_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    expect_word(32'h0020_0093); send(I_ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
    expect_word(32'h0030_0093); send(I_ADDI, 5'd1, 5'd0, 5'd0, 32'd3);
    chk("full_ready_low", req_ready, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("full_head_stable", out_word, 32'h0010_0093);
    chk("full_ready_held", req_ready, 32'd0);
    out_ready = 1'b1;
    expect_word(32'h0040_0093); send(I_ADDI, 5'd1, 5'd0, 5'd0, 32'd4);
    drain();
    chk("cnt_fill", word_cnt, exp_cnt);

    @(posedge clk); #1; out_ready = 1'b0;
    req_inst = I_ADDI; req_rd = 5'd5; req_rs1 = 5'd0; req_imm = 32'h1234_5678;
    req_valid = 1'b1;
    chk("pre_exp_ready", req_ready, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    chk("exp2_first_valid", out_valid, 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_mid_valid", out_valid, 32'd0);
    chk("rst_mid_cnt", word_cnt, 32'd0);
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("rst_mid_no_second", out_valid, 32'd0);
    chk("rst_mid_cnt_after", word_cnt, 32'd0);
    expect_word(32'h0000_0013); send(I_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
    drain();
    chk("cnt_recover", word_cnt, exp_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Synthesizable RV32I instruction encoder: accepts decoded instruction descriptors (`e_all_inst` opcode plus register fields and a 32-bit immediate) and produces 32-bit machine words on a buffered valid/ready stream. It does the reverse of the decode-stage instruction classification. It sits in the bench/boot path, in front of the instruction-memory loader, so directed programs can be written symbolically. ADDI with an out-of-range immediate and `rs1 = x0` is expanded into a LUI+ADDI pair.

## Interface
- `DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `CNT_W`, 16: width of emitted-word counter.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  descriptor valid.
- `req_ready`  out  1  encoder can accept a descriptor.
- `req_inst`  in  `e_all_inst`  instruction kind.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices.
- `req_imm`  in  32  immediate, byte-offset/value semantics (not pre-shifted, except LUI/AUIPC which carry the full upper value).
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_word`  out  32  encoded instruction.
- `err_illegal`  out  1  one-cycle pulse: request rejected.
- `word_cnt`  out  `CNT_W`  words pushed into the FIFO since reset; wraps.

## Operation
- Handshake: transfer when `req_valid && req_ready`. `req_ready = (state == S_IDLE) && (fifo_count <= DEPTH-2)`, conservatively reserving room for an expansion.
- Formats:
  - R: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; SUB/SRA use funct7 `0100000`.
  - I: ADDI…ANDI, LB/LH/LW/LBU/LHU, JALR; uses `imm[11:0]`.
  - Shifts SLLI/SRLI/SRAI: use `imm[4:0]`; SRAI funct7 `0100000`.
  - S: SB/SH/SW.
  - B: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - U: LUI/AUIPC from `imm[31:12]`.
  - J: JAL.
  - NOP → `0x00000013`.
- Rejection: `err_illegal` pulses the cycle after acceptance and no word is pushed, when any of the following holds:
  - I/S immediate outside [-2048, 2047] (except the expansion case below);
  - B immediate outside ±4 KiB or J immediate outside ±1 MiB;
  - `imm[0]` = 1 on B/J;
  - `imm[11:0]` ≠ 0 on LUI/AUIPC;
  - `imm[31:5]` ≠ 0 on a shift;
  - M/atomic/unsupported enum.
- Expansion: ADDI with out-of-range immediate and `rs1 = 0`.
  - `hi = (imm + 0x800) >> 12`, `lo = imm - (hi << 12)`.
  - Emit `LUI rd, hi`, then `ADDI rd, rd, lo`.
  - With `rs1 ≠ 0` the request is rejected instead.
- FSM:
  - `S_IDLE`: an accepted expansion → `S_EXP2`; all other accepted requests stay in `S_IDLE`.
  - `S_EXP2`: pushes the saved ADDI and returns to `S_IDLE` unconditionally; space is guaranteed by the `req_ready` rule.
- `word_cnt` increments once per push.

## Timing
- Reset values: `req_ready` is a function of reset state (`S_IDLE`, count 0), so it reads 1 during reset. All other outputs reset to 0: `out_valid` = 0, `out_word` = 0, `err_illegal` = 0, `word_cnt` = 0, FIFO empty.
- Latency: word pushed at the edge after acceptance; `out_valid` high that next cycle if the FIFO was empty. Second expansion word is pushed one cycle after the first.
- FIFO:
  - Simultaneous push and pop keeps the count.
  - Pop only when `out_valid && out_ready`.
  - Read/write pointers wrap modulo `DEPTH`.
  - `out_word` is stable while `out_valid && !out_ready`.
- Full: `req_ready` low whenever count > DEPTH-2; never overflow.
- Reset asserted mid-expansion: pending second word is discarded, FIFO cleared, state returns to `S_IDLE`.

## Structure
- `instructions_pkg`: add opcode/funct3/funct7 constants where missing.
- `encoder_pkg`: FSM enum `e_enc_state`, immediate range limits, and a function per format (`enc_r`, `enc_i`, `enc_s`, `enc_b`, `enc_u`, `enc_j`).
- Sub-module: `enc_fifo`, parameterized `DEPTH`, 32-bit.

## Test plan
- ADDI x1,x0,5 → one word `0x00500093`; `word_cnt` = 1.
- ADD x3,x1,x2 → `0x002081B3`; SW x2,12(x1) → `0x0020A623`; BEQ x1,x2,+8 → `0x00208463`.
- ADDI x5,x0,0x12345678 → `0x123452B7` then `0x67828293` on consecutive cycles. ADDI x5,x0,0x800 → `0x000012B7`, `0x80028293`.
- BEQ with imm = 3, and ADDI x5,x1,0x1000 → `err_illegal` pulse each; no push; `word_cnt` unchanged.
- Hold `out_ready` = 0 and stream NOPs: FIFO reaches 3 entries (DEPTH=4), then `req_ready` drops; release `out_ready` → words drain in order with no loss or duplication.
- Assert `rst_n` low in `S_EXP2` → `out_valid` 0 immediately, no second word after release, `word_cnt` = 0.
